instr_fetch_ctrl: RTL and testbench

Fetch-side controller that sits between the program counter and instruction memory. It reads `addr` from the PC, fetches the instruction word over a req/ack handshake, and presents it to decode through a valid/ready handshake. It then drives the PC's control inputs (`pc_en`, `jump_or_not`, `ext`) to advance the PC or take a branch. It is the producer of the PC control interface and the consumer of its `addr` output.

---
 rtl/instr_fetch_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
// Fetch-side controller between the program counter and instruction memory.
// It reads the PC value from addr and fetches one instruction word over a
// req/ack handshake. The word is offered to decode over a valid/ready
// handshake. The controller then pulses pc_en for one cycle, with
// jump_or_not/ext describing the branch resolved from the instruction.
//
// Optional feature macro: IFETCH_SKIP_NOP_EN
//   When defined, an all-zero instruction word is dropped as a NOP. It is not
//   presented to decode, and the FSM advances the PC directly.
//
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   addr              - current PC value (sampled when a fetch starts)
//   stall             - inhibits starting a new fetch (sampled in IDLE only)
//   zero_flag         - ALU zero flag, used by BRZ
//   imem_req/addr     - instruction memory request and read address
//   imem_ack/rdata    - memory acknowledge and instruction word
//   ir/ir_valid       - instruction register and its valid flag to decode
//   ir_ready          - decode accepts ir
//   pc_en             - one-cycle PC update strobe
//   jump_or_not, ext  - branch taken and sign-extended offset, qualified by pc_en
//   fetch_err         - sticky memory timeout flag
// -----------------------------------------------------------------------------
module instr_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned OFFSET_W = 8,
  parameter logic [3:0]  OPC_JMP  = 4'hC,
  parameter logic [3:0]  OPC_BRZ  = 4'hD,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               stall,
  input  logic               zero_flag,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic               pc_en,
  output logic               jump_or_not,
  output logic [15:0]        ext,
  output logic               fetch_err
);

  localparam int unsigned EXT_W = 16;
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    HOLD = 3'd2,
    ADV  = 3'd3,
    ERR  = 3'd4
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic               imem_req_q;
  logic [ADDR_W-1:0]  imem_addr_q;
  logic [INSTR_W-1:0] ir_q;
  logic               ir_valid_q;
  logic               pc_en_q;
  logic               jump_q;
  logic [EXT_W-1:0]   ext_q;
  logic               fetch_err_q;

  // Branch resolution from the held instruction.
  logic [3:0]       opcode_c;
  logic             taken_c;
  logic [EXT_W-1:0] offset_sext_c;

  always_comb begin
    opcode_c      = ir_q[INSTR_W-1 -: 4];
    taken_c       = 1'b0;
    offset_sext_c = {{(EXT_W-OFFSET_W){ir_q[OFFSET_W-1]}}, ir_q[OFFSET_W-1:0]};
    if (opcode_c == OPC_JMP) begin
      taken_c = 1'b1;
    end else if (opcode_c == OPC_BRZ) begin
      taken_c = zero_flag;
    end
  end

  // Fetch FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      pc_en_q     <= 1'b0;
      jump_q      <= 1'b0;
      ext_q       <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!stall) begin
            imem_addr_q <= addr;
            imem_req_q  <= 1'b1;
            wait_cnt_q  <= '0;
            state_q     <= REQ;
          end
        end

        REQ: begin
          if (imem_ack) begin
            imem_req_q <= 1'b0;
`ifdef IFETCH_SKIP_NOP_EN
            if (imem_rdata == '0) begin
              // NOP: skip decode and advance the PC sequentially.
              pc_en_q <= 1'b1;
              jump_q  <= 1'b0;
              ext_q   <= '0;
              state_q <= ADV;
            end else begin
              ir_q       <= imem_rdata;
              ir_valid_q <= 1'b1;
              state_q    <= HOLD;
            end
`else
            ir_q       <= imem_rdata;
            ir_valid_q <= 1'b1;
            state_q    <= HOLD;
`endif
          end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
            // MAX_WAIT cycles without an ack: give up.
            imem_req_q  <= 1'b0;
            fetch_err_q <= 1'b1;
            state_q     <= ERR;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end

        HOLD: begin
          if (ir_ready) begin
            ir_valid_q <= 1'b0;
            pc_en_q    <= 1'b1;
            jump_q     <= taken_c;
            ext_q      <= taken_c ? offset_sext_c : '0;
            state_q    <= ADV;
          end
        end

        ADV: begin
          pc_en_q <= 1'b0;
          jump_q  <= 1'b0;
          ext_q   <= '0;
          state_q <= IDLE;
        end

        ERR: begin
          // Terminal until reset.
          imem_req_q  <= 1'b0;
          fetch_err_q <= 1'b1;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign ir          = ir_q;
  assign ir_valid    = ir_valid_q;
  assign pc_en       = pc_en_q;
  assign jump_or_not = jump_q;
  assign ext         = ext_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_ctrl
// Directed self-checking bench for instr_fetch_ctrl. Inputs change #1 after
// a rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        stall;
  logic        zero_flag;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        pc_en;
  logic        jump_or_not;
  logic [15:0] ext;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .stall      (stall),
    .zero_flag  (zero_flag),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .pc_en      (pc_en),
    .jump_or_not(jump_or_not),
    .ext        (ext),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},  32'(imem_req),    32'h0);
    check({tag, "_iadr"}, 32'(imem_addr),   32'h0);
    check({tag, "_ir"},   32'(ir),          32'h0);
    check({tag, "_irv"},  32'(ir_valid),    32'h0);
    check({tag, "_pce"},  32'(pc_en),       32'h0);
    check({tag, "_jmp"},  32'(jump_or_not), 32'h0);
    check({tag, "_ext"},  32'(ext),         32'h0);
    check({tag, "_err"},  32'(fetch_err),   32'h0);
  endtask

  // Starts in REQ with imem_req high; runs one fetch with a 1-cycle ack and
  // ir_ready=1, then checks the next fetch starts 4 cycles after the first.
  task automatic do_fetch(input string tag, input logic [15:0] word, input logic zf,
                          input logic exp_jmp, input logic [15:0] exp_ext);
    imem_rdata = word;
    imem_ack   = 1'b1;
    ir_ready   = 1'b1;
    zero_flag  = zf;
    tick();
    check({tag, "_ir"},    32'(ir),       32'(word));
    check({tag, "_irv"},   32'(ir_valid), 32'h1);
    check({tag, "_req0"},  32'(imem_req), 32'h0);
    check({tag, "_pce0"},  32'(pc_en),    32'h0);
    imem_ack = 1'b0;
    tick();
    check({tag, "_irv0"},  32'(ir_valid),    32'h0);
    check({tag, "_pce"},   32'(pc_en),       32'h1);
    check({tag, "_jmp"},   32'(jump_or_not), 32'(exp_jmp));
    check({tag, "_ext"},   32'(ext),         32'(exp_ext));
    addr = addr + 16'h1;
    tick();
    check({tag, "_pceoff"}, 32'(pc_en),       32'h0);
    check({tag, "_jmpoff"}, 32'(jump_or_not), 32'h0);
    check({tag, "_extoff"}, 32'(ext),         32'h0);
    tick();
    check({tag, "_nreq"},  32'(imem_req),  32'h1);
    check({tag, "_nadr"},  32'(imem_addr), 32'(addr));
  endtask

  initial begin
    logic [15:0] held_addr;

    rst        = 1'b1;
    addr       = 16'h0000;
    stall      = 1'b1;
    zero_flag  = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    ir_ready   = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");

    // Start a fetch, then reset mid-REQ.
    rst   = 1'b0;
    stall = 1'b0;
    addr  = 16'h0010;
    tick();
    check("start_req",  32'(imem_req),  32'h1);
    check("start_addr", 32'(imem_addr), 32'h0010);
    tick();
    rst = 1'b1;
    #1;
    check_idle_outputs("midreq_rst");
    tick();
    rst = 1'b0;
    tick();
    check("rel_req",  32'(imem_req),  32'h1);
    check("rel_addr", 32'(imem_addr), 32'h0010);

    do_fetch("plain",  16'h1234, 1'b0, 1'b0, 16'h0000);
    do_fetch("jmp",    16'hC0F0, 1'b0, 1'b1, 16'hFFF0);
    do_fetch("brz_z0", 16'hD005, 1'b0, 1'b0, 16'h0000);
    do_fetch("brz_z1", 16'hD005, 1'b1, 1'b1, 16'h0005);
    do_fetch("jmp_pos", 16'hC07F, 1'b0, 1'b1, 16'h007F);

    // Delayed ack: request and address held stable.
    held_addr = imem_addr;
    imem_ack  = 1'b0;
    addr      = 16'h0ABC;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dly_req",  32'(imem_req),  32'h1);
      check("dly_addr", 32'(imem_addr), 32'(held_addr));
    end
    imem_rdata = 16'h2222;
    imem_ack   = 1'b1;
    ir_ready   = 1'b0;
    tick();
    check("bp_irv", 32'(ir_valid), 32'h1);
    imem_ack   = 1'b0;
    imem_rdata = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ir",   32'(ir),       32'h2222);
      check("bp_irv1", 32'(ir_valid), 32'h1);
      check("bp_pce",  32'(pc_en),    32'h0);
    end
    ir_ready = 1'b1;
    tick();
    check("bp_pce1", 32'(pc_en),    32'h1);
    check("bp_irv0", 32'(ir_valid), 32'h0);

    // Stall in IDLE: no request.
    stall = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_req", 32'(imem_req), 32'h0);
    end
    stall = 1'b0;
    addr  = 16'h0040;
    tick();
    check("unstall_req",  32'(imem_req),  32'h1);
    check("unstall_addr", 32'(imem_addr), 32'h0040);

    // Timeout: 14 unacked cycles are fine, the 15th raises the error.
    imem_ack = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("to_err14", 32'(fetch_err), 32'h0);
    check("to_req14", 32'(imem_req),  32'h1);
    tick();
    check("to_err15", 32'(fetch_err), 32'h1);
    check("to_req15", 32'(imem_req),  32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 16'h1111;
    for (int i = 0; i < 4; i++) tick();
    check("err_sticky", 32'(fetch_err), 32'h1);
    check("err_noreq",  32'(imem_req),  32'h0);
    check("err_irv",    32'(ir_valid),  32'h0);
    imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("err_rst", 32'(fetch_err), 32'h0);
    tick();
    rst = 1'b0;

    // All-zero instruction word.
    tick();
    check("nop_req", 32'(imem_req), 32'h1);
    imem_rdata = 16'h0000;
    imem_ack   = 1'b1;
    ir_ready   = 1'b1;
    tick();
    imem_ack = 1'b0;
`ifdef IFETCH_SKIP_NOP_EN
    check("nop_irv", 32'(ir_valid),    32'h0);
    check("nop_pce", 32'(pc_en),       32'h1);
    check("nop_jmp", 32'(jump_or_not), 32'h0);
    tick();
    check("nop_irv2", 32'(ir_valid), 32'h0);
    check("nop_pce2", 32'(pc_en),    32'h0);
`else
    check("nop_irv", 32'(ir_valid), 32'h1);
    check("nop_pce", 32'(pc_en),    32'h0);
    tick();
    check("nop_pce2", 32'(pc_en),       32'h1);
    check("nop_jmp",  32'(jump_or_not), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
